// File: rtl/xalu_muldiv.sv
// xalu_muldiv: HI/LO multiply/divide unit for the EX stage.
// Multiply runs through a MUL_LAT-deep product shift chain, with optional
// accumulate/subtract into {hi,lo}. Divide is radix-2 restoring on magnitudes
// (WIDTH edges) followed by a single sign-fix/write edge. A flush aborts any
// in-flight operation without touching hi/lo.
module xalu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + MUL_LAT + 2);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // multiply path
  logic [2*WIDTH-1:0] r_chain [MUL_LAT];
  logic [1:0]         r_macc;          // 00 write, 01 add, 10 subtract

  // divide path
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_den;
  logic [WIDTH-1:0]   r_a;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_dz;
  logic               r_dsigned;

  // decode
  logic               w_op_mul;
  logic               w_op_div;
  logic               w_op_signed;
  logic [1:0]         w_op_acc;
  logic               w_accept;

  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_res;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_div_sh;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_sub;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic               w_mul_fin;
  logic               w_div_fin;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Opcode decode and acceptance qualification.
  always_comb begin
    w_op_mul    = 1'b0;
    w_op_div    = 1'b0;
    w_op_signed = 1'b0;
    w_op_acc    = 2'b00;
    case (op)
      4'd0: begin w_op_mul = 1'b1; w_op_signed = 1'b1; end
      4'd1: begin w_op_mul = 1'b1; end
      4'd2: begin w_op_div = 1'b1; w_op_signed = 1'b1; end
      4'd3: begin w_op_div = 1'b1; end
      4'd4: begin w_op_mul = 1'b1; w_op_signed = 1'b1; w_op_acc = 2'b01; end
      4'd5: begin w_op_mul = 1'b1; w_op_acc = 2'b01; end
      4'd6: begin w_op_mul = 1'b1; w_op_signed = 1'b1; w_op_acc = 2'b10; end
      4'd7: begin w_op_mul = 1'b1; w_op_acc = 2'b10; end
      default: ;
    endcase
    w_accept = op_valid & (r_state == S_IDLE) & ~flush & (op <= 4'd9);
  end

  // Operand extension, product, divide magnitudes and the restoring step.
  always_comb begin
    // Sign- or zero-extending to 2*WIDTH lets one truncated multiply serve both signednesses.
    w_ext_a = w_op_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    w_ext_b = w_op_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    w_prod  = w_ext_a * w_ext_b;

    w_a_neg = w_op_signed & op_a[WIDTH-1];
    w_b_neg = w_op_signed & op_b[WIDTH-1];
    w_a_mag = w_a_neg ? ('0 - op_a) : op_a;
    w_b_mag = w_b_neg ? ('0 - op_b) : op_b;

    // Partial remainder stays below the divisor, so WIDTH bits of the difference suffice.
    w_div_sh  = {r_rem, r_quo[WIDTH-1]};
    w_div_ge  = (w_div_sh >= {1'b0, r_den});
    w_div_sub = w_div_sh[WIDTH-1:0] - r_den;

    w_q_fix = r_q_neg ? ('0 - r_quo) : r_quo;
    w_r_fix = r_r_neg ? ('0 - r_rem) : r_rem;

    case (r_macc)
      2'b01:   w_mul_res = {r_hi, r_lo} + r_chain[MUL_LAT-1];
      2'b10:   w_mul_res = {r_hi, r_lo} - r_chain[MUL_LAT-1];
      default: w_mul_res = r_chain[MUL_LAT-1];
    endcase

    w_mul_fin = (r_state == S_MUL) & (r_cnt == MUL_LAST);
    w_div_fin = (r_state == S_DIV) & (r_cnt == DIV_LAST);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // FSM next state; flush wins over completion.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept & w_op_mul)      w_state_nx = S_MUL;
        else if (w_accept & w_op_div) w_state_nx = S_DIV;
      end
      S_MUL:   if (flush | w_mul_fin) w_state_nx = S_IDLE;
      S_DIV:   if (flush | w_div_fin) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Datapath: operand capture, product chain, divider iteration and HI/LO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_macc    <= 2'b00;
      r_rem     <= '0;
      r_quo     <= '0;
      r_den     <= '0;
      r_a       <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_dz      <= 1'b0;
      r_dsigned <= 1'b0;
      for (int unsigned k = 0; k < MUL_LAT; k++) r_chain[k] <= '0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= (r_state == S_IDLE) ? '0 : r_cnt + 1'b1;

      if (w_accept & (op == 4'd8)) r_hi <= op_a;
      if (w_accept & (op == 4'd9)) r_lo <= op_a;

      if (flush) begin
        for (int unsigned k = 0; k < MUL_LAT; k++) r_chain[k] <= '0;
      end else begin
        r_chain[0] <= (w_accept & w_op_mul) ? w_prod : '0;
        for (int unsigned k = 1; k < MUL_LAT; k++) r_chain[k] <= r_chain[k-1];
      end
      if (w_accept & w_op_mul) r_macc <= w_op_acc;

      if (w_mul_fin & ~flush) begin
        {r_hi, r_lo} <= w_mul_res;
        r_done       <= 1'b1;
      end

      if (w_accept & w_op_div) begin
        r_rem     <= '0;
        r_quo     <= w_a_mag;
        r_den     <= w_b_mag;
        r_a       <= op_a;
        r_q_neg   <= w_a_neg ^ w_b_neg;
        r_r_neg   <= w_a_neg;
        r_dz      <= (op_b == '0);
        r_dsigned <= w_op_signed;
      end else if ((r_state == S_DIV) & ~flush) begin
        if (!w_div_fin) begin
          r_rem <= w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_div_ge};
        end else begin
          r_done <= 1'b1;
          if (r_dz) begin
            r_hi <= r_a;
            r_lo <= (r_dsigned & r_a[WIDTH-1]) ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
          end else begin
            r_hi <= w_r_fix;
            r_lo <= w_q_fix;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xalu_muldiv.sv
// tb_xalu_muldiv: directed literal checks plus randomized traffic compared
// every cycle against a latency/arithmetic reference model of the HI/LO unit.
module tb_xalu_muldiv;
  localparam int W   = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset, op_valid, flush;
  logic [3:0]    op;
  logic [W-1:0]  op_a, op_b;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  xalu_muldiv #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference arithmetic: returns {hi,lo} after the op, given {hi,lo} before the write.
  function automatic logic [63:0] model_res(logic [3:0] o, logic [31:0] a, logic [31:0] b,
                                            logic [63:0] acc);
    logic [63:0] p;
    longint sa, sb, q, r;
    p = '0;
    if (o == 0 || o == 4 || o == 6) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else                            p = {32'b0, a} * {32'b0, b};
    case (o)
      4'd0, 4'd1: return p;
      4'd4, 4'd5: return acc + p;
      4'd6, 4'd7: return acc - p;
      4'd2: begin
        if (b == 0) return {a, (a[31] ? 32'h1 : 32'hFFFF_FFFF)};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return acc;
    endcase
  endfunction

  // Reference model: countdown of remaining busy cycles, result applied on the last one.
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [3:0]  m_op;
  int          m_rem;
  logic        m_done;

  always @(posedge clk) begin
    if (reset) begin
      m_hi <= '0; m_lo <= '0; m_rem <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        if (flush) m_rem <= 0;
        else begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            {m_hi, m_lo} <= model_res(m_op, m_a, m_b, {m_hi, m_lo});
            m_done <= 1'b1;
          end
        end
      end else if (op_valid && !flush && op <= 4'd9) begin
        case (op)
          4'd8: m_hi <= op_a;
          4'd9: m_lo <= op_a;
          default: begin
            m_op <= op; m_a <= op_a; m_b <= op_b;
            m_rem <= (op == 4'd2 || op == 4'd3) ? W + 1 : LAT;
          end
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'b0, busy}, {31'b0, (m_rem > 0)});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; op_a = a; op_b = b;
    tick();
    op_valid = 1'b0; op = 4'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle_bound", {31'b0, busy}, 32'd0);
  endtask

  task automatic run(input string name, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input int cyc, input logic [31:0] ehi,
                     input logic [31:0] elo);
    int n;
    issue(o, a, b);
    wait_idle(n);
    chk({name, " busy_cycles"}, 32'(n), 32'(cyc));
    chk({name, " done"}, {31'b0, done}, 32'd1);
    chk({name, " hi"}, hi, ehi);
    chk({name, " lo"}, lo, elo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1; op_valid = 1'b0; flush = 1'b0; op = '0; op_a = '0; op_b = '0;
    repeat (3) tick();
    reset = 1'b0;
    cmp_en = 1'b1;
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);

    run("MULT",  4'd0, 32'hFFFF_FFFF, 32'h2, 3,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("MULTU", 4'd1, 32'hFFFF_FFFF, 32'h2, 3,  32'h0000_0001, 32'hFFFF_FFFE);
    run("DIV",   4'd2, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("DIVU",  4'd3, 32'h7,         32'h2, 33, 32'h1,         32'h3);
    run("DIVMIN",4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    run("DIVU0", 4'd3, 32'h5,         32'h0, 33, 32'h5,         32'hFFFF_FFFF);
    run("DIV0",  4'd2, 32'hFFFF_FFFB, 32'h0, 33, 32'hFFFF_FFFB, 32'h1);

    issue(4'd9, 32'hFFFF_FFFF, 32'h0);
    chk("MTLO busy", {31'b0, busy}, 32'd0);
    issue(4'd8, 32'h0, 32'h0);
    chk("MTHI hi", hi, 32'h0);
    chk("MTLO lo", lo, 32'hFFFF_FFFF);
    run("MADDU", 4'd5, 32'h1, 32'h1, 3, 32'h1, 32'h0);
    run("MSUB",  4'd6, 32'h1, 32'h1, 3, 32'h0, 32'hFFFF_FFFF);

    // Flush a divide part way through.
    issue(4'd2, 32'd100, 32'd3);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush done", {31'b0, done}, 32'd0);
    chk("flush hi", hi, 32'h0);
    chk("flush lo", lo, 32'hFFFF_FFFF);
    repeat (40) tick();
    chk("flush lo late", lo, 32'hFFFF_FFFF);

    // op_valid together with flush is rejected, including MTHI.
    op_valid = 1'b1; op = 4'd8; op_a = 32'h1234; flush = 1'b1;
    tick();
    op_valid = 1'b0; flush = 1'b0;
    chk("vflush hi", hi, 32'h0);
    chk("vflush busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a multiply.
    issue(4'd0, 32'd5, 32'd6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    repeat (4) tick();
    chk("rst lo late", lo, 32'h0);

    // Requests while busy are ignored.
    issue(4'd1, 32'd3, 32'd4);
    op_valid = 1'b1; op = 4'd8; op_a = 32'h9999;
    tick();
    op_valid = 1'b0;
    wait_idle(n);
    chk("busyign hi", hi, 32'h0);
    chk("busyign lo", lo, 32'd12);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom % 500) == 0;
      op_valid = ($urandom % 3) == 0;
      op       = 4'($urandom);
      op_a     = pick();
      op_b     = pick();
      flush    = ($urandom % 60) == 0;
      tick();
    end
    reset = 1'b0; op_valid = 1'b0; flush = 1'b0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
